// File: rtl/lfsr_capture_display.sv
// Captures the upstream LFSR byte on each debounced button press, drives two
// active-low hex digits, counts captures and measures the value's recurrence period.
module lfsr_capture_display #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PERIOD_MAX      = 511
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [7:0] lfsr_in,
  output logic [7:0] cap_value,
  output logic       cap_valid,
  output logic [7:0] capture_cnt,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi,
  output logic [8:0] period,
  output logic       period_valid,
  output logic       period_ovf
);

  localparam int PER_W = 9;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_MAX);

  logic             sync_p0;
  logic             sync_p1;
  logic             db_p2;
  logic             db_d_p3;
  logic [CNT_W-1:0] db_cnt;
  logic             measuring;
  logic [PER_W-1:0] pcnt;
  logic             cap_pulse;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Rising edge of the debounced level only; release produces nothing.
  assign cap_pulse = db_p2 & ~db_d_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0      <= 1'b0;
      sync_p1      <= 1'b0;
      db_p2        <= 1'b0;
      db_d_p3      <= 1'b0;
      db_cnt       <= '0;
      cap_value    <= '0;
      cap_valid    <= 1'b0;
      capture_cnt  <= '0;
      measuring    <= 1'b0;
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      period_ovf   <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronizer for the asynchronous button
      sync_p0 <= btn;
      sync_p1 <= sync_p0;

      // p2: level accepted only after DEBOUNCE_CYCLES consecutive differing samples
      if (sync_p1 == db_p2) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_p2  <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end

      // p3: edge detect, capture and period measurement
      db_d_p3 <= db_p2;

      if (cap_pulse) begin
        cap_value    <= lfsr_in;
        cap_valid    <= 1'b1;
        capture_cnt  <= capture_cnt + 8'd1;
        pcnt         <= PER_W'(1);
        measuring    <= 1'b1;
        period_valid <= 1'b0;
        period_ovf   <= 1'b0;
      end else if (measuring) begin
        if (lfsr_in == cap_value) begin
          period       <= pcnt;
          period_valid <= 1'b1;
          measuring    <= 1'b0;
        end else if (pcnt == PER_LAST) begin
          period     <= PER_LAST;
          period_ovf <= 1'b1;
          measuring  <= 1'b0;
        end else begin
          pcnt <= pcnt + PER_W'(1);
        end
      end
    end
  end

  assign seg_lo = cap_valid ? hex_to_seg(cap_value[3:0]) : 7'h7F;
  assign seg_hi = cap_valid ? hex_to_seg(cap_value[7:4]) : 7'h7F;

endmodule
